// File: rtl/cast_noc_pkg.sv
// Shared port-count, mask type and port indices for the 5-port multicast router.
package cast_noc_pkg;
  localparam int NPORT = 5;
  localparam int PTR_W = 3;

  typedef logic [NPORT-1:0] port_mask_t;

  localparam int PORT_L = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_N = 4;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NPORT - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/cast_alloc_pick.sv
// Combinational rotating scan: grants each eligible input its whole mask or nothing,
// honouring outputs reserved by urgent (starving) requesters.
module cast_alloc_pick
  import cast_noc_pkg::*;
(
  input  logic [PTR_W-1:0]       rr_ptr_i,
  input  port_mask_t             eligible_i,
  input  port_mask_t             urgent_i,
  input  port_mask_t [NPORT-1:0] mask_i,
  input  port_mask_t             free_i,
  output port_mask_t             win_o,
  output logic                   any_win_o,
  output logic [PTR_W-1:0]       first_o
);

  port_mask_t reserved;
  port_mask_t free_v;
  logic [PTR_W-1:0] pi;

  always_comb begin
    reserved = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (urgent_i[i]) reserved = reserved | mask_i[i];
    end
  end

  // free_v shrinks as winners are found so later inputs only see leftovers
  always_comb begin
    free_v    = free_i;
    win_o     = '0;
    any_win_o = 1'b0;
    first_o   = '0;
    pi        = '0;
    for (int k = 0; k < NPORT; k++) begin
      int idx;
      idx = int'(rr_ptr_i) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      pi = PTR_W'(idx);
      if (eligible_i[pi] && ((mask_i[pi] & ~free_v) == '0) &&
          (urgent_i[pi] || ((mask_i[pi] & reserved) == '0))) begin
        win_o[pi] = 1'b1;
        free_v    = free_v & ~mask_i[pi];
        if (!any_win_o) begin
          any_win_o = 1'b1;
          first_o   = pi;
        end
      end
    end
  end

endmodule

// File: rtl/cast_switch_allocator.sv
// Multicast switch allocator: atomic all-or-nothing grants, wormhole locks held
// until tail handshake, round-robin with age-based starvation override.
module cast_switch_allocator
  import cast_noc_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] req_valid,
  input  logic [4:0] req_mask_vc0,
  input  logic [4:0] req_mask_vc1,
  input  logic [4:0] req_mask_vc2,
  input  logic [4:0] req_mask_vc3,
  input  logic [4:0] req_mask_vc4,
  input  logic [4:0] valid_in,
  input  logic [4:0] ready_out,
  input  logic [4:0] tail_in,
  output logic [4:0] selVCfromVC0,
  output logic [4:0] selVCfromVC1,
  output logic [4:0] selVCfromVC2,
  output logic [4:0] selVCfromVC3,
  output logic [4:0] selVCfromVC4,
  output logic [4:0] out_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  port_mask_t [NPORT-1:0] req_mask;
  port_mask_t [NPORT-1:0] lock_all;
  port_mask_t             eligible;
  port_mask_t             urgent;
  port_mask_t             fire;
  port_mask_t             win;
  port_mask_t             busy_chk;
  logic                   any_win;
  logic [PTR_W-1:0]       first_win;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [PTR_W-1:0]       rr_ptr_d;

  assign req_mask[0] = req_mask_vc0;
  assign req_mask[1] = req_mask_vc1;
  assign req_mask[2] = req_mask_vc2;
  assign req_mask[3] = req_mask_vc3;
  assign req_mask[4] = req_mask_vc4;

  assign selVCfromVC0 = lock_all[0];
  assign selVCfromVC1 = lock_all[1];
  assign selVCfromVC2 = lock_all[2];
  assign selVCfromVC3 = lock_all[3];
  assign selVCfromVC4 = lock_all[4];

  always_comb begin
    out_busy = '0;
    for (int i = 0; i < NPORT; i++) out_busy = out_busy | lock_all[i];
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_in
      port_mask_t       lock_q, lock_d;
      logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

      assign eligible[gi] = req_valid[gi] & (|req_mask[gi]) & (lock_q == '0);
      assign urgent[gi]   = eligible[gi] & (wait_cnt_q == CNT_W'(STARVE_LIMIT));
      // a tail handshake only matters while the input actually holds outputs
      assign fire[gi]     = valid_in[gi] & ready_out[gi] & tail_in[gi] & (|lock_q);

      always_comb begin
        lock_d = lock_q;
        if (win[gi])       lock_d = req_mask[gi];
        else if (fire[gi]) lock_d = '0;
      end

      always_comb begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (win[gi] || !eligible[gi])                   wait_cnt_d = '0;
        else if (wait_cnt_q == CNT_W'(STARVE_LIMIT))    wait_cnt_d = wait_cnt_q;
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          lock_q     <= '0;
          wait_cnt_q <= '0;
        end else begin
          lock_q     <= lock_d;
          wait_cnt_q <= wait_cnt_d;
        end
      end

      assign lock_all[gi] = lock_q;

      a_no_spurious_change: assert property (@(posedge clk) disable iff (!rstn)
        !(win[gi] || fire[gi]) |-> (lock_d == lock_q));

      for (gj = gi + 1; gj < NPORT; gj++) begin : g_pair
        a_disjoint: assert property (@(posedge clk) disable iff (!rstn)
          (lock_all[gi] & lock_all[gj]) == '0);
      end
    end
  endgenerate

  assign busy_chk = lock_all[0] | lock_all[1] | lock_all[2] | lock_all[3] | lock_all[4];

  a_busy_or: assert property (@(posedge clk) disable iff (!rstn) out_busy == busy_chk);

  cast_alloc_pick u_pick (
    .rr_ptr_i   (rr_ptr_q),
    .eligible_i (eligible),
    .urgent_i   (urgent),
    .mask_i     (req_mask),
    .free_i     (~out_busy),
    .win_o      (win),
    .any_win_o  (any_win),
    .first_o    (first_win)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_win) rr_ptr_d = ptr_inc(first_win);
  end

  always_ff @(posedge clk) begin
    if (!rstn) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule
